ahb_ext_sram: RTL and testbench

AHB_EXT_SRAM -- requirements
Module: ahb_ext_sram

---
 rtl/ahb_ext_sram_pkg.sv | 25 ++
 rtl/ahb_ext_sram_ram.sv | 30 +++
 rtl/ahb_ext_sram.sv | 127 ++++++++++++
 tb/tb_ahb_ext_sram.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ahb_ext_sram_pkg.sv
// Shared definitions for the external AHB SRAM subordinate: bus encodings,
// response codes and the transfer-tracking FSM state type.
package ahb_ext_sram_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'd0;
  localparam logic [1:0] HTRANS_BUSY   = 2'd1;
  localparam logic [1:0] HTRANS_NONSEQ = 2'd2;
  localparam logic [1:0] HTRANS_SEQ    = 2'd3;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_ERR1,
    ST_ERR2
  } state_t;

  // NONSEQ and SEQ are the only transfer types that carry a real beat.
  function automatic logic is_xfer(input logic [1:0] htrans);
    return htrans[1];
  endfunction

endpackage

// File: rtl/ahb_ext_sram_ram.sv
// Single-port storage with per-byte write enables, asynchronous read and
// synchronous write. Contents are deliberately never reset.
module ram1p_bwe #(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned DEPTH  = 4096
) (
  input  logic                     i_clk,
  input  logic                     i_we,
  input  logic [DATA_W/8-1:0]      i_be,
  input  logic [$clog2(DEPTH)-1:0] i_addr,
  input  logic [DATA_W-1:0]        i_wdata,
  output logic [DATA_W-1:0]        o_rdata
);

  logic [DATA_W-1:0] r_mem [DEPTH];

  // Byte-lane masked write on the rising edge.
  always_ff @(posedge i_clk) begin
    if (i_we) begin
      for (int unsigned i = 0; i < DATA_W / 8; i++) begin
        if (i_be[i]) begin
          r_mem[i_addr][i*8 +: 8] <= i_wdata[i*8 +: 8];
        end
      end
    end
  end

  assign o_rdata = r_mem[i_addr];

endmodule

// File: rtl/ahb_ext_sram.sv
// AHB subordinate fronting an on-chip SRAM: programmable wait states,
// two-cycle ERROR response for out-of-range or oversized transfers,
// byte-strobed writes committed at the end of the data phase.
module ahb_ext_sram
  import ahb_ext_sram_pkg::*;
#(
  parameter int unsigned ADDR_BITS   = 32,
  parameter int unsigned DATA_W      = 64,
  parameter int unsigned DEPTH_WORDS = 4096,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic                  HCLK,
  input  logic                  HRESETn,
  input  logic                  HSELEXT,
  input  logic [ADDR_BITS-1:0]  HADDR,
  input  logic [1:0]            HTRANS,
  input  logic                  HWRITE,
  input  logic [2:0]            HSIZE,
  input  logic [2:0]            HBURST,
  input  logic [DATA_W-1:0]     HWDATA,
  input  logic [DATA_W/8-1:0]   HWSTRB,
  input  logic                  HREADY,
  output logic [DATA_W-1:0]     HRDATAEXT,
  output logic                  HREADYEXT,
  output logic                  HRESPEXT
);

  localparam int unsigned BSH = $clog2(DATA_W / 8);
  localparam int unsigned AW  = $clog2(DEPTH_WORDS);

  state_t               r_state, w_state_nxt;
  logic [3:0]           r_cnt, w_cnt_nxt;
  logic [AW-1:0]        r_waddr;
  logic                 r_write;
  logic                 r_dvalid;
  logic                 w_ready;
  logic                 w_accept;
  logic                 w_valid;
  logic                 w_we;
  logic [ADDR_BITS-1:0] w_word_idx;
  logic [DATA_W-1:0]    w_rdata;
  logic                 w_unused;

  // Bursts are handled beat by beat, so HBURST and HTRANS[0] carry no information here.
  assign w_unused = ^{HBURST, HTRANS[0]};

  // Range check uses the full word index; truncation to AW bits happens only when latching.
  assign w_word_idx = HADDR >> BSH;
  assign w_valid    = (w_word_idx < ADDR_BITS'(DEPTH_WORDS)) && (HSIZE <= 3'(BSH));
  assign w_ready    = (r_state == ST_IDLE) || (r_state == ST_ERR2);
  assign w_accept   = HSELEXT & HREADY & is_xfer(HTRANS) & w_ready;

  // Only a valid write whose data phase is completing in IDLE may touch the array.
  assign w_we = r_dvalid & r_write & (r_state == ST_IDLE);

  // FSM state and wait counter.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Next-state: accept in IDLE/ERR2, count down in WAIT, ERR1 always precedes ERR2.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    unique case (r_state)
      ST_IDLE, ST_ERR2: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = '0;
        if (w_accept) begin
          if (!w_valid) begin
            w_state_nxt = ST_ERR1;
          end else if (WAIT_STATES != 0) begin
            w_state_nxt = ST_WAIT;
            w_cnt_nxt   = 4'(WAIT_STATES - 1);
          end
        end
      end
      ST_WAIT: begin
        if (r_cnt == '0) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_cnt_nxt = r_cnt - 4'd1;
        end
      end
      ST_ERR1: w_state_nxt = ST_ERR2;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Address-phase capture; the data-phase flag drops once an un-followed phase completes.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_waddr  <= '0;
      r_write  <= 1'b0;
      r_dvalid <= 1'b0;
    end else if (w_accept) begin
      r_waddr  <= w_word_idx[AW-1:0];
      r_write  <= HWRITE;
      r_dvalid <= w_valid;
    end else if (w_ready) begin
      r_dvalid <= 1'b0;
    end
  end

  ram1p_bwe #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH_WORDS)
  ) u_ram (
    .i_clk   (HCLK),
    .i_we    (w_we),
    .i_be    (HWSTRB),
    .i_addr  (r_waddr),
    .i_wdata (HWDATA),
    .o_rdata (w_rdata)
  );

  assign HREADYEXT = w_ready;
  assign HRESPEXT  = ((r_state == ST_ERR1) || (r_state == ST_ERR2)) ? HRESP_ERROR : HRESP_OKAY;
  assign HRDATAEXT = (r_dvalid && !r_write && (r_state == ST_IDLE)) ? w_rdata : '0;

endmodule

// File: tb/tb_ahb_ext_sram.sv
// Two subordinates on one bus (zero and three wait states) driven by a
// pipelined AHB manager; a monitor compares each completed data phase
// against expectations queued at address-phase acceptance.
module tb_ahb_ext_sram;

  localparam logic [1:0] T_IDLE = 2'd0, T_BUSY = 2'd1, T_NONSEQ = 2'd2, T_SEQ = 2'd3;

  logic        HCLK = 1'b0;
  logic        HRESETn = 1'b1;
  logic        sel0 = 1'b0, sel3 = 1'b0;
  logic [31:0] HADDR = '0;
  logic [1:0]  HTRANS = T_IDLE;
  logic        HWRITE = 1'b0;
  logic [2:0]  HSIZE = 3'd3;
  logic [2:0]  HBURST = '0;
  logic [63:0] HWDATA = '0;
  logic [7:0]  HWSTRB = '0;
  logic [63:0] rd0, rd3, HRDATA;
  logic        rdy0, rdy3, rsp0, rsp3, HREADY, HRESP;
  logic        dp_sel;

  always #5 HCLK = ~HCLK;

  assign HREADY = dp_sel ? rdy3 : rdy0;
  assign HRESP  = dp_sel ? rsp3 : rsp0;
  assign HRDATA = dp_sel ? rd3  : rd0;

  always @(posedge HCLK or negedge HRESETn)
    if (!HRESETn) dp_sel <= 1'b0;
    else if (HREADY) dp_sel <= sel3;

  ahb_ext_sram #(.ADDR_BITS(32), .DATA_W(64), .DEPTH_WORDS(4096), .WAIT_STATES(0)) u_dut0 (
    .HCLK(HCLK), .HRESETn(HRESETn), .HSELEXT(sel0), .HADDR(HADDR), .HTRANS(HTRANS),
    .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST), .HWDATA(HWDATA), .HWSTRB(HWSTRB),
    .HREADY(HREADY), .HRDATAEXT(rd0), .HREADYEXT(rdy0), .HRESPEXT(rsp0));

  ahb_ext_sram #(.ADDR_BITS(32), .DATA_W(64), .DEPTH_WORDS(4096), .WAIT_STATES(3)) u_dut3 (
    .HCLK(HCLK), .HRESETn(HRESETn), .HSELEXT(sel3), .HADDR(HADDR), .HTRANS(HTRANS),
    .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST), .HWDATA(HWDATA), .HWSTRB(HWSTRB),
    .HREADY(HREADY), .HRDATAEXT(rd3), .HREADYEXT(rdy3), .HRESPEXT(rsp3));

  typedef struct {
    bit          rd;
    bit          err;
    logic [63:0] data;
    int          low;
  } exp_t;

  exp_t        q[$];
  logic [63:0] mdl [2][4096];
  int          total = 0, bad = 0;
  int          cyc = 0, acc_cyc = 0;

  always @(posedge HCLK) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic wait_hready();
    int n;
    for (n = 0; n < 64; n++) begin
      @(negedge HCLK);
      if (HREADY) break;
    end
    if (n == 64) begin
      total++;
      bad++;
      $display("FAIL hready_timeout: HREADY stayed 0 for 64 cycles, want 1");
    end
  endtask

  // Present one address phase, hold it until accepted, then drive its data phase.
  task automatic xfer(input bit d3, input bit wr, input logic [31:0] addr, input logic [2:0] size,
                      input logic [63:0] wd, input logic [7:0] st, input logic [1:0] tr);
    exp_t        e;
    logic [31:0] word;
    sel0   = !d3;
    sel3   = d3;
    HADDR  = addr;
    HWRITE = wr;
    HSIZE  = size;
    HTRANS = tr;
    HBURST = 3'($urandom_range(0, 7));
    wait_hready();
    @(posedge HCLK);
    #1;
    acc_cyc = cyc;
    word  = addr >> 3;
    e.err = (word >= 32'd4096) || (size > 3'd3);
    e.rd  = !wr;
    e.low = e.err ? 1 : (d3 ? 3 : 0);
    if (!e.err && wr)
      for (int b = 0; b < 8; b++)
        if (st[b]) mdl[d3][word[11:0]][b*8 +: 8] = wd[b*8 +: 8];
    e.data = (!wr && !e.err) ? mdl[d3][word[11:0]] : 64'd0;
    q.push_back(e);
    HWDATA = wd;
    HWSTRB = st;
    sel0   = 1'b0;
    sel3   = 1'b0;
    HTRANS = T_IDLE;
  endtask

  task automatic idle_cycle(input bit busy, input bit d3);
    sel0   = busy && !d3;
    sel3   = busy && d3;
    HTRANS = busy ? T_BUSY : T_IDLE;
    wait_hready();
    @(posedge HCLK);
    #1;
    sel0   = 1'b0;
    sel3   = 1'b0;
    HTRANS = T_IDLE;
  endtask

  // Monitor: tracks the data phase on the bus and scores it when HREADY closes it.
  initial begin : monitor
    bit   act;
    int   low;
    exp_t e;
    act = 1'b0;
    low = 0;
    forever begin
      @(negedge HCLK);
      if (!HRESETn) begin
        act = 1'b0;
        low = 0;
        q.delete();
      end else begin
        if (act) begin
          if (!HREADY) begin
            low++;
            if (q.size() != 0) check("resp_wait", 64'(HRESP), 64'(q[0].err));
            if (low > 40) begin
              total++;
              bad++;
              $display("FAIL data_phase_timeout: %0d wait cycles, want at most 3", low);
              act = 1'b0;
              low = 0;
            end
          end else begin
            if (q.size() == 0) begin
              total++;
              bad++;
              $display("FAIL unexpected_xfer: data phase ended with no expectation queued");
            end else begin
              e = q.pop_front();
              check("waits", 64'(low), 64'(e.low));
              check("resp", 64'(HRESP), 64'(e.err));
              check("rdata", HRDATA, (e.rd && !e.err) ? e.data : 64'd0);
            end
            act = 1'b0;
            low = 0;
          end
        end else begin
          check("idle_ready", 64'(HREADY), 64'd1);
          check("idle_resp", 64'(HRESP), 64'd0);
          check("idle_rdata", HRDATA, 64'd0);
        end
        if (!act && HREADY && (sel0 || sel3) && HTRANS[1]) act = 1'b1;
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin : driver
    logic [63:0] save;
    int          prev, r;
    bit          d3, wr;
    logic [31:0] a;
    logic [2:0]  sz;

    #1 HRESETn = 1'b0;
    @(negedge HCLK);
    check("rst_ready0", 64'(rdy0), 64'd1);
    check("rst_resp0", 64'(rsp0), 64'd0);
    check("rst_rdata0", rd0, 64'd0);
    check("rst_ready3", 64'(rdy3), 64'd1);
    check("rst_resp3", 64'(rsp3), 64'd0);
    check("rst_rdata3", rd3, 64'd0);
    @(negedge HCLK);
    HRESETn = 1'b1;
    @(posedge HCLK);
    #1;

    // Preload every word that is later read.
    for (int d = 0; d < 2; d++) begin
      for (int w = 0; w < 33; w++)
        xfer(d[0], 1'b1, 32'(w * 8), 3'd3, {$urandom, $urandom}, 8'hFF, (w == 0) ? T_NONSEQ : T_SEQ);
      xfer(d[0], 1'b1, 32'h200, 3'd3, {$urandom, $urandom}, 8'hFF, T_NONSEQ);
    end

    // Zero-wait write then overlapping read of the same word.
    xfer(1'b0, 1'b1, 32'h100, 3'd3, 64'h1122334455667788, 8'hFF, T_NONSEQ);
    prev = acc_cyc;
    xfer(1'b0, 1'b0, 32'h100, 3'd3, 64'd0, 8'h00, T_NONSEQ);
    check("b2b_wr_rd", 64'(acc_cyc - prev), 64'd1);

    // Partial strobe keeps the upper four bytes.
    xfer(1'b0, 1'b1, 32'h100, 3'd3, 64'hFFFFFFFFFFFFFFFF, 8'h0F, T_NONSEQ);
    xfer(1'b0, 1'b0, 32'h100, 3'd3, 64'd0, 8'h00, T_NONSEQ);

    // Single read with three wait states.
    idle_cycle(1'b0, 1'b0);
    xfer(1'b1, 1'b0, 32'h100, 3'd3, 64'd0, 8'h00, T_NONSEQ);
    idle_cycle(1'b0, 1'b0);

    // Out of range and oversized transfers must not disturb word 0.
    for (int d = 0; d < 2; d++) begin
      xfer(d[0], 1'b0, 32'h8000, 3'd3, 64'd0, 8'h00, T_NONSEQ);
      xfer(d[0], 1'b1, 32'h8000, 3'd3, 64'hA5A5A5A5A5A5A5A5, 8'hFF, T_NONSEQ);
      xfer(d[0], 1'b1, 32'h8, 3'd4, 64'h5A5A5A5A5A5A5A5A, 8'hFF, T_NONSEQ);
      xfer(d[0], 1'b0, 32'h0, 3'd3, 64'd0, 8'h00, T_NONSEQ);
      xfer(d[0], 1'b0, 32'h8, 3'd3, 64'd0, 8'h00, T_NONSEQ);
    end
    idle_cycle(1'b0, 1'b0);

    // Reset during the second wait cycle of a write abandons it.
    save = mdl[1][64];
    xfer(1'b1, 1'b1, 32'h200, 3'd3, 64'hDEADBEEF0BADF00D, 8'hFF, T_NONSEQ);
    @(posedge HCLK);
    #2;
    check("rst_pre_ready", 64'(rdy3), 64'd0);
    HRESETn = 1'b0;
    #1;
    check("rst_mid_ready", 64'(rdy3), 64'd1);
    check("rst_mid_resp", 64'(rsp3), 64'd0);
    check("rst_mid_rdata", rd3, 64'd0);
    mdl[1][64] = save;
    repeat (2) @(negedge HCLK);
    HRESETn = 1'b1;
    @(posedge HCLK);
    #1;
    xfer(1'b1, 1'b0, 32'h200, 3'd3, 64'd0, 8'h00, T_NONSEQ);

    // Four-beat write burst then four reads, checking beat spacing.
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 8; i++) begin
        xfer(d[0], (i < 4), 32'((i % 4) * 8), 3'd3, {$urandom, $urandom}, 8'hFF,
             (i % 4 == 0) ? T_NONSEQ : T_SEQ);
        if (i > 0) check("beat_spacing", 64'(acc_cyc - prev), (d == 0) ? 64'd1 : 64'd4);
        prev = acc_cyc;
      end
    end

    // Randomised traffic across both subordinates.
    for (int n = 0; n < 300; n++) begin
      r  = $urandom_range(0, 99);
      d3 = 1'($urandom_range(0, 1));
      wr = 1'($urandom_range(0, 1));
      sz = 3'($urandom_range(0, 3));
      a  = 32'($urandom_range(0, 31) * 8);
      if (r < 8) begin
        idle_cycle(1'($urandom_range(0, 1)), d3);
      end else begin
        if (r < 12) a = 32'h8000 + 32'($urandom_range(0, 31) * 8);
        else if (r < 14) a = 32'hFFFFFFF8;
        else if (r < 17) sz = 3'($urandom_range(4, 7));
        xfer(d3, wr, a, sz, {$urandom, $urandom}, 8'($urandom), ($urandom_range(0, 1) != 0) ? T_SEQ : T_NONSEQ);
      end
    end

    repeat (6) idle_cycle(1'b0, 1'b0);
    check("queue_empty", 64'(q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
